// File: rtl/trap_ctl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : trap_ctl
// Brief    : Trap/xRET commit controller: xepc/xcause/xtval write strobes,
//            pipeline flush, PC redirect and privilege update.
//            Optional macro TRAP_VECTORED_EN enables vectored interrupt entry.
// Revision : 1.0 - initial release
// ============================================================================
module trap_ctl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc,
  input  logic [63:0] exc_cause,
  input  logic [63:0] exc_val,
  input  logic        irq,
  input  logic [5:0]  irq_cause,
  input  logic        mret,
  input  logic        sret,
  input  logic [63:0] commit_pc,
  input  logic        stall_mem,
  input  logic [1:0]  priv,
  input  logic [63:0] medeleg,
  input  logic [63:0] mideleg,
  input  logic [63:0] mtvec,
  input  logic [63:0] stvec,
  input  logic [63:0] mepc,
  input  logic [63:0] sepc,
  input  logic [1:0]  mpp,
  input  logic        spp,
  output logic        flush,
  output logic        pc_vld,
  output logic [63:0] pc_nxt,
  output logic        we_m,
  output logic        we_s,
  output logic [63:0] epc_o,
  output logic [63:0] cause_o,
  output logic [63:0] tval_o,
  output logic        priv_we,
  output logic [1:0]  priv_nxt,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_WRITE    = 2'b01,
    S_REDIRECT = 2'b10
  } state_t;

  localparam logic [1:0] C_PRIV_S = 2'b01;
  localparam logic [1:0] C_PRIV_M = 2'b11;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_epc;
  logic [63:0] r_cause;
  logic [63:0] r_tval;
  logic [63:0] r_pc_tgt;
  logic [1:0]  r_priv_tgt;
  logic        r_to_s;

  logic        w_accept;
  logic        w_is_trap;
  logic [63:0] w_trap_cause;
  logic [5:0]  w_idx;
  logic        w_deleg;
  logic        w_to_s;
  logic [63:0] w_tvec;
  logic [63:0] w_tvec_base;
  logic [63:0] w_vector;
  logic [63:0] w_ret_pc;
  logic [1:0]  w_ret_priv;

  assign w_is_trap    = exc | irq;
  assign w_accept     = rst_n && (r_state == S_IDLE) && !stall_mem &&
                        (exc | irq | mret | sret);
  assign w_trap_cause = exc ? exc_cause : {1'b1, 57'd0, irq_cause};
  assign w_idx        = w_trap_cause[5:0];
  assign w_deleg      = exc ? medeleg[w_idx] : mideleg[w_idx];
  assign w_to_s       = (priv != C_PRIV_M) && w_deleg;
  assign w_tvec       = w_to_s ? stvec : mtvec;
  assign w_tvec_base  = w_tvec & ~64'h3;

`ifdef TRAP_VECTORED_EN
  // Interrupts only vector when the handler base selects vectored mode.
  assign w_vector = ((w_tvec[1:0] == 2'b01) && !exc) ?
                    (w_tvec_base + {56'd0, w_idx, 2'b00}) : w_tvec_base;
`else
  assign w_vector = w_tvec_base;
`endif

  assign w_ret_pc   = mret ? (mepc & ~64'h3) : (sepc & ~64'h3);
  assign w_ret_priv = mret ? mpp : {1'b0, spp};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_epc      <= 64'd0;
      r_cause    <= 64'd0;
      r_tval     <= 64'd0;
      r_pc_tgt   <= 64'd0;
      r_priv_tgt <= 2'b00;
      r_to_s     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        if (w_is_trap) begin
          r_epc      <= commit_pc & ~64'h1;
          r_cause    <= w_trap_cause;
          r_tval     <= exc ? exc_val : 64'd0;
          r_to_s     <= w_to_s;
          r_pc_tgt   <= w_vector;
          r_priv_tgt <= w_to_s ? C_PRIV_S : C_PRIV_M;
        end else begin
          r_pc_tgt   <= w_ret_pc;
          r_priv_tgt <= w_ret_priv;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_is_trap ? S_WRITE : S_REDIRECT;
      end
      S_WRITE:    w_state_nxt = S_REDIRECT;
      S_REDIRECT: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Flush is combinational so the accepting cycle already kills the pipe.
  assign busy     = (r_state != S_IDLE);
  assign flush    = w_accept || busy;
  assign we_m     = (r_state == S_WRITE) && !r_to_s;
  assign we_s     = (r_state == S_WRITE) && r_to_s;
  assign pc_vld   = (r_state == S_REDIRECT);
  assign priv_we  = (r_state == S_REDIRECT);
  assign pc_nxt   = (r_state == S_REDIRECT) ? r_pc_tgt : 64'd0;
  assign priv_nxt = r_priv_tgt;
  assign epc_o    = r_epc;
  assign cause_o  = r_cause;
  assign tval_o   = r_tval;

endmodule
`default_nettype wire

// File: doc/trap_ctl.md
TRAP_CTL -- requirements
Module: trap_ctl

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 exc  in  1  synchronous exception present at commit point (from exception unit).
REQ-004 exc_cause  in  64  exception cause code; bit 63 always 0.
REQ-005 exc_val  in  64  trap value for exception.
REQ-006 irq  in  1  enabled interrupt pending (already masked by mie/mstatus).
REQ-007 irq_cause  in  6  interrupt code.
REQ-008 mret / sret  in  1 each  xRET at commit point.
REQ-009 commit_pc  in  64  PC of instruction at commit point.
REQ-010 stall_mem  in  1  commit stage stalled; no event accepted while high.
REQ-011 priv  in  2  current privilege (00 U, 01 S, 11 M).
REQ-012 medeleg, mideleg  in  64 each  delegation masks.
REQ-013 mtvec, stvec, mepc, sepc  in  64 each  CSR values.
REQ-014 mpp  in  2; spp  in  1  previous-privilege fields.
REQ-015 flush  out  1  kill all pipeline stages.
REQ-016 pc_vld  out  1  one-cycle redirect strobe; pc_nxt  out  64  redirect target.
REQ-017 we_m / we_s  out  1 each  one-cycle strobe writing xepc/xcause/xtval and xstatus trap-entry fields.
REQ-018 epc_o, cause_o, tval_o  out  64 each  values for the strobed write.
REQ-019 priv_we  out  1; priv_nxt  out  2  privilege update strobe and value.
REQ-020 busy  out  1  FSM not in IDLE.

Function
REQ-021 FSM states IDLE, WRITE, REDIRECT; 2-bit encoding.
REQ-022 IDLE accepts event only when stall_mem=0; priority exc > irq > mret > sret.
REQ-023 Trap accepted at edge N: latch commit_pc, cause (irq: bit63=1, low bits irq_cause), tval (irq: 0), target mode; go WRITE.
REQ-024 flush SHALL be 1 combinationally in IDLE cycle where event accepted and in all non-IDLE cycles.
REQ-025 Target S iff priv!=11 and selected deleg bit (medeleg/mideleg indexed by cause[5:0]) is 1; otherwise M.
REQ-026 WRITE: exactly one of we_m/we_s high for one cycle with latched epc/cause/tval; go REDIRECT.
REQ-027 REDIRECT (trap): pc_vld=1, pc_nxt=vector (REQ-034), priv_we=1, priv_nxt=target (01 or 11); go IDLE.
REQ-028 mret accepted: go REDIRECT directly; pc_nxt=mepc, priv_nxt=mpp; no we_* strobe.
REQ-029 sret accepted: as REQ-028 with sepc and priv_nxt={1'b0,spp}.
REQ-030 exc, irq, mret, sret ignored while busy=1; no queuing.
REQ-031 Trap latency: pc_vld two cycles after acceptance edge; xRET latency one cycle.
REQ-032 pc_nxt bits [1:0] always 0; epc_o bit 0 forced 0.

Reset
REQ-033 rst_n=0 at any edge, including mid-trap: state IDLE, flush/pc_vld/we_m/we_s/priv_we/busy=0, latched registers 0, pc_nxt=0.

Configuration
REQ-034 TRAP_VECTORED_EN defined: if tvec[1:0]=01 and latched cause is interrupt, vector = (tvec & ~3) + 4*cause[5:0]; else tvec & ~3.
REQ-035 TRAP_VECTORED_EN undefined: tvec[1:0] ignored; vector always tvec & ~3.

Verification
REQ-036 priv=11, exc=1, exc_cause=2, commit_pc=0x8000_0010, mtvec=0x8000_0100 -> next cycle we_m=1 epc_o=0x8000_0010 cause_o=2; following cycle pc_vld=1 pc_nxt=0x8000_0100 priv_nxt=11.
REQ-037 priv=00, exc cause 8, medeleg[8]=1, stvec=0x8000_0200 -> we_s=1, pc_nxt=0x8000_0200, priv_nxt=01.
REQ-038 Vectored build, priv=11, irq=1 irq_cause=7, mtvec=0x8000_0101 -> cause_o=0x8000_0000_0000_0007, pc_nxt=0x8000_011C; non-vectored build -> 0x8000_0100.
REQ-039 exc and irq both high, stall_mem=0 -> exception taken; irq asserted in WRITE ignored; stall_mem=1 with exc -> no acceptance, flush=0.
REQ-040 mret=1, mepc=0x8000_0400, mpp=00 -> next cycle pc_vld=1 pc_nxt=0x8000_0400 priv_nxt=00, no we_*.
REQ-041 rst_n=0 during WRITE -> next cycle busy=0, no we_* or pc_vld pulse.
